// File: rtl/serial_transmitter.sv
// -----------------------------------------------------------------------------
// serial_transmitter
//
// Sends one byte per accepted request as a framed serial bit stream on tx:
// start bit (0), eight data bits LSB first, one parity bit, then STOP_BITS
// idle-high stop bits. The parallel side uses a valid/ready handshake and
// accepts one byte per frame.
//
// Parameters
//   CLKS_PER_BIT  clk cycles each serial bit is held on tx (>= 1)
//   STOP_BITS     number of stop bits (1 or 2)
//   PARITY_ODD    0: even parity, 1: odd parity
//
// Ports
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset; aborts any frame in flight
//   data_in  in   byte to send, sampled only on the accepting edge
//   valid    in   request to send data_in
//   ready    out  high in IDLE, when a new byte can be accepted
//   tx       out  registered serial line, idles high
//   busy     out  high while a frame is in progress (inverse of ready)
//   done     out  one-cycle pulse in the final clk of the final stop bit
// -----------------------------------------------------------------------------
module serial_transmitter #(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic              STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state,    w_state_next;
   logic [7:0]        r_shift,    w_shift_next;
   logic [2:0]        r_bit_idx,  w_bit_idx_next;
   logic [BAUD_W-1:0] r_baud,     w_baud_next;
   logic              r_stop_cnt, w_stop_cnt_next;
   logic              r_parity,   w_parity_next;
   logic              r_tx,       w_tx_next;
   logic              w_bit_end;
   logic              w_done;

   assign w_bit_end = (r_baud == BAUD_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_baud     <= '0;
         r_stop_cnt <= 1'b0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_next;
         r_shift    <= w_shift_next;
         r_bit_idx  <= w_bit_idx_next;
         r_baud     <= w_baud_next;
         r_stop_cnt <= w_stop_cnt_next;
         r_parity   <= w_parity_next;
         r_tx       <= w_tx_next;
      end
   end

   // tx is loaded with the value of the bit being entered, on the same edge as
   // the state change, so the line is a clean register output at every
   // boundary.
   always_comb begin
      // NOTE: every comb output is defaulted first so no path can infer a latch.
      w_state_next    = r_state;
      w_shift_next    = r_shift;
      w_bit_idx_next  = r_bit_idx;
      w_baud_next     = r_baud;
      w_stop_cnt_next = r_stop_cnt;
      w_parity_next   = r_parity;
      w_tx_next       = r_tx;
      w_done          = 1'b0;

      if (r_state == S_IDLE) begin
         w_tx_next = 1'b1;
         if (valid) begin
            w_state_next  = S_START;
            w_shift_next  = data_in;
            w_parity_next = (^data_in) ^ PARITY_ODD;
            w_baud_next   = '0;
            w_tx_next     = 1'b0;
         end
      end else begin
         w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
         if (w_bit_end) begin
            case (r_state)
               S_START: begin
                  w_state_next   = S_DATA;
                  w_bit_idx_next = 3'd0;
                  w_tx_next      = r_shift[0];
               end
               S_DATA: begin
                  // Index wraps 7 -> 0 on exit, leaving it ready for the next frame.
                  w_shift_next   = r_shift >> 1;
                  w_bit_idx_next = r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     w_state_next = S_PARITY;
                     w_tx_next    = r_parity;
                  end else begin
                     w_tx_next    = r_shift[1];
                  end
               end
               S_PARITY: begin
                  w_state_next    = S_STOP;
                  w_stop_cnt_next = 1'b0;
                  w_tx_next       = 1'b1;
               end
               S_STOP: begin
                  w_tx_next = 1'b1;
                  if (r_stop_cnt == STOP_LAST) begin
                     w_state_next = S_IDLE;
                     w_done       = 1'b1;
                  end else begin
                     w_stop_cnt_next = r_stop_cnt + 1'b1;
                  end
               end
               default: begin
                  w_state_next = S_IDLE;
                  w_tx_next    = 1'b1;
               end
            endcase
         end
      end
   end

   assign tx    = r_tx;
   assign ready = (r_state == S_IDLE);
   assign busy  = ~ready;
   // Decoded from registers so it coincides with the last stop-bit clk.
   assign done  = w_done;

endmodule

// File: tb/tb_serial_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_transmitter
//
// Three transmitters with different parameter sets share clk and rst_n:
//   u0: CLKS_PER_BIT=1, STOP_BITS=1, even parity
//   u1: CLKS_PER_BIT=1, STOP_BITS=1, odd parity
//   u2: CLKS_PER_BIT=4, STOP_BITS=2, even parity
// Expected line levels and bytes are pushed to queues when a byte is offered
// and popped as the line is observed; a small decoder rebuilds each byte from
// the line like the receiving end would.
// -----------------------------------------------------------------------------
module tb_serial_transmitter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_in [3];
   logic       valid   [3];
   logic       ready_w [3];
   logic       tx_w    [3];
   logic       busy_w  [3];
   logic       done_w  [3];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_acc [3];

   logic       exp_bits  [$];
   logic [7:0] exp_bytes [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(1'b0)) u0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in[0]), .valid(valid[0]),
      .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

   serial_transmitter #(.CLKS_PER_BIT(1), .STOP_BITS(1), .PARITY_ODD(1'b1)) u1 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in[1]), .valid(valid[1]),
      .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

   serial_transmitter #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_ODD(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in[2]), .valid(valid[2]),
      .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected line level for every clk of one frame, plus the byte itself.
   task automatic push_frame(input logic [7:0] b, input int cpb, input int stops, input logic odd);
      logic par;
      logic lvl;
      par = (^b) ^ odd;
      for (int k = 0; k < 10 + stops; k++) begin
         if (k == 0)      lvl = 1'b0;
         else if (k <= 8) lvl = b[k-1];
         else if (k == 9) lvl = par;
         else             lvl = 1'b1;
         for (int c = 0; c < cpb; c++) exp_bits.push_back(lvl);
      end
      exp_bytes.push_back(b);
   endtask

   // Entered at the negedge of the first clk after acceptance; returns at the
   // negedge of the last frame clk.
   task automatic check_frame(input int inst, input int cpb, input int stops,
                              input logic odd, input logic hold_valid);
      int         n;
      logic [10:0] obs;
      logic       e;
      logic [7:0] eb;
      n   = (10 + stops) * cpb;
      obs = '0;
      for (int i = 0; i < n; i++) begin
         if (hold_valid && i < n - 1) begin
            valid[inst]   = 1'b1;
            data_in[inst] = 8'($urandom);
         end else begin
            valid[inst]   = 1'b0;
         end
         check($sformatf("sb_bits_u%0d", inst), 32'(exp_bits.size() > 0), 1);
         if (exp_bits.size() > 0) begin
            e = exp_bits.pop_front();
            check($sformatf("tx_u%0d_clk%0d", inst, i), tx_w[inst], e);
         end
         check($sformatf("ready_u%0d_clk%0d", inst, i), ready_w[inst], 0);
         check($sformatf("busy_u%0d_clk%0d", inst, i), busy_w[inst], 1);
         check($sformatf("done_u%0d_clk%0d", inst, i), done_w[inst], 32'(i == n - 1));
         if ((i % cpb) == cpb - 1 && (i / cpb) < 11) obs[i / cpb] = tx_w[inst];
         if (i < n - 1) @(negedge clk);
      end
      check($sformatf("sb_bytes_u%0d", inst), 32'(exp_bytes.size() > 0), 1);
      if (exp_bytes.size() > 0) begin
         eb = exp_bytes.pop_front();
         check($sformatf("start_u%0d", inst), obs[0], 0);
         check($sformatf("rx_byte_u%0d", inst), obs[8:1], eb);
         check($sformatf("parity_u%0d", inst), obs[9], (^eb) ^ odd);
      end
   endtask

   task automatic send(input int inst, input logic [7:0] b, input int cpb, input int stops,
                       input logic odd, input logic hold_valid, input logic b2b);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!ready_w[inst] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      check($sformatf("ready_wait_u%0d", inst), ready_w[inst], 1);
      valid[inst]   = 1'b1;
      data_in[inst] = b;
      push_frame(b, cpb, stops, odd);
      @(negedge clk);
      if (b2b) check($sformatf("period_u%0d", inst), cyc - last_acc[inst], (10 + stops) * cpb + 1);
      last_acc[inst] = cyc;
      check_frame(inst, cpb, stops, odd, hold_valid);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         valid[i]    = 1'b0;
         data_in[i]  = 8'h00;
         last_acc[i] = 0;
      end
      // Reset held with a pending request: nothing may be accepted.
      rst_n      = 1'b0;
      valid[0]   = 1'b1;
      data_in[0] = 8'hFF;
      repeat (5) begin
         @(negedge clk);
         check("rst_tx",    tx_w[0],    1);
         check("rst_ready", ready_w[0], 1);
         check("rst_busy",  busy_w[0],  0);
         check("rst_done",  done_w[0],  0);
      end
      // Release with valid still high: frame starts on the next edge.
      rst_n = 1'b1;
      push_frame(8'hFF, 1, 1, 1'b0);
      @(negedge clk);
      last_acc[0] = cyc;
      check_frame(0, 1, 1, 1'b0, 1'b0);

      // Basic frame and parity cases.
      send(0, 8'hA5, 1, 1, 1'b0, 1'b0, 1'b0);
      send(0, 8'h07, 1, 1, 1'b0, 1'b0, 1'b0);
      send(1, 8'h07, 1, 1, 1'b1, 1'b0, 1'b0);
      send(0, 8'h00, 1, 1, 1'b0, 1'b0, 1'b0);

      // Slow baud with two stop bits, then a back-to-back frame.
      send(2, 8'h3C, 4, 2, 1'b0, 1'b0, 1'b0);
      send(2, 8'h81, 4, 2, 1'b0, 1'b0, 1'b1);

      // valid held with changing data during the frame; then back-to-back.
      send(0, 8'h11, 1, 1, 1'b0, 1'b1, 1'b0);
      send(0, 8'h22, 1, 1, 1'b0, 1'b0, 1'b1);

      // Loopback byte, then abort a frame during data bit 3.
      send(0, 8'h5A, 1, 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("abort_ready", ready_w[0], 1);
      valid[0]   = 1'b1;
      data_in[0] = 8'h00;
      @(negedge clk);
      valid[0] = 1'b0;
      check("abort_start", tx_w[0], 0);
      repeat (4) @(negedge clk);
      check("abort_bit3_tx",   tx_w[0],   0);
      check("abort_bit3_busy", busy_w[0], 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_tx",    tx_w[0],    1);
      check("abort_ready2", ready_w[0], 1);
      check("abort_busy",  busy_w[0],  0);
      check("abort_done",  done_w[0],  0);
      repeat (3) begin
         @(negedge clk);
         check("abort_hold_tx",   tx_w[0],   1);
         check("abort_hold_done", done_w[0], 0);
      end
      rst_n = 1'b1;
      send(0, 8'hC3, 1, 1, 1'b0, 1'b0, 1'b0);

      // Line must stay idle afterwards.
      repeat (3) begin
         @(negedge clk);
         check("idle_tx",    tx_w[0],    1);
         check("idle_ready", ready_w[0], 1);
      end
      check("sb_bits_drained",  exp_bits.size(),  0);
      check("sb_bytes_drained", exp_bytes.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
